// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: sequencer phase encoding, reset/halt address defaults
// and the primary opcode enumeration used by the decode stage.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC1  = 2'd1,
    ST_EXEC2  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LWL     = 6'h22,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_LWR     = 6'h26,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SW      = 6'h2B
  } opcode_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

  // Link register value: the instruction after the delay slot.
  function automatic logic [31:0] link_addr(input logic [31:0] addr);
    return addr + 32'd8;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FETCH/EXEC1/EXEC2 phase FSM with pc update,
// single branch delay slot and halt-on-jump-to-HALT_ADDR.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        waitrequest,
  input  logic        data_stall,
  input  logic        needs_exec2,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_address,
  output logic        instr_read,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [31:0] pc,
  output logic [31:0] pc_link,
  output logic        active
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic        delay_pending_q, delay_pending_d;
  logic        branch_seen_q, branch_seen_d;

  logic        in_exec;
  logic        take_branch;
  logic        commit;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    saved_target_d  = saved_target_q;
    delay_pending_d = delay_pending_q;
    branch_seen_d   = branch_seen_q;
    commit          = 1'b0;

    unique case (state_q)
      ST_FETCH:  if (!waitrequest) state_d = ST_EXEC1;
      ST_EXEC1:  if (needs_exec2) state_d = ST_EXEC2;
                 else             commit  = 1'b1;
      ST_EXEC2:  if (!data_stall) commit  = 1'b1;
      ST_HALTED: ;
    endcase

    // A delay-slot instruction cannot start another branch; a later
    // assertion (EXEC2 over EXEC1) overwrites the latched target.
    in_exec     = (state_q == ST_EXEC1) || (state_q == ST_EXEC2);
    take_branch = in_exec && branch_valid && !delay_pending_q;
    if (take_branch) begin
      saved_target_d = branch_target;
      branch_seen_d  = 1'b1;
    end

    if (commit) begin
      state_d       = ST_FETCH;
      branch_seen_d = 1'b0;
      if (delay_pending_q) begin
        pc_d            = saved_target_q;
        delay_pending_d = 1'b0;
        if (saved_target_q == HALT_ADDR) state_d = ST_HALTED;
      end else begin
        pc_d            = pc_q + 32'd4;
        delay_pending_d = branch_seen_q || take_branch;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_FETCH;
      pc_q            <= RESET_VECTOR;
      saved_target_q  <= 32'd0;
      delay_pending_q <= 1'b0;
      branch_seen_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      saved_target_q  <= saved_target_d;
      delay_pending_q <= delay_pending_d;
      branch_seen_q   <= branch_seen_d;
    end
  end

  assign fetch         = (state_q == ST_FETCH);
  assign exec1         = (state_q == ST_EXEC1);
  assign exec2         = (state_q == ST_EXEC2);
  assign active        = (state_q != ST_HALTED);
  assign instr_read    = fetch;
  assign pc            = pc_q;
  assign instr_address = pc_q;
  assign pc_link       = link_addr(pc_q);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a transaction-level model predicts
// the per-cycle phase/pc trace, a negedge monitor compares the DUT against it.
module tb_instr_sequencer;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] HALT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        waitrequest = 1'b0;
  logic        data_stall = 1'b0;
  logic        needs_exec2 = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] instr_address, pc, pc_link;
  logic        instr_read, fetch, exec1, exec2, active;

  instr_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(HALT)) dut (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest),
    .data_stall(data_stall), .needs_exec2(needs_exec2),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_address(instr_address), .instr_read(instr_read),
    .fetch(fetch), .exec1(exec1), .exec2(exec2),
    .pc(pc), .pc_link(pc_link), .active(active)
  );

  always #5 clk = ~clk;

  // Expected strobes are {fetch, exec1, exec2}.
  typedef struct {
    logic [2:0]  strb;
    logic [31:0] pc;
    logic        act;
  } exp_t;

  typedef struct {
    logic        wr, ds, ne, bv;
    logic [31:0] bt;
    logic [2:0]  strb;
  } cyc_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   end_req = 1'b0;

  // Architectural model: next pc, pending delay-slot target, halted flag.
  logic [31:0] m_pc = RV;
  logic [31:0] m_target = 32'd0;
  bit          m_pending = 1'b0;
  bit          m_halted = 1'b0;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [31:0] rtarget();
    logic [31:0] r;
    r = $urandom;
    if (($urandom % 4) == 0) return HALT;
    return {r[31:2], 2'b00};
  endfunction

  task automatic drive_cycle(input logic rn, input logic wr, input logic ds,
                             input logic ne, input logic bv, input logic [31:0] bt,
                             input logic [2:0] strb, input logic [31:0] epc,
                             input logic eact);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n       = rn;
    waitrequest   = wr;
    data_stall    = ds;
    needs_exec2   = ne;
    branch_valid  = bv;
    branch_target = bt;
    e.strb = strb;
    e.pc   = epc;
    e.act  = eact;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(1'b0, rbit(), rbit(), rbit(), rbit(), $urandom, 3'b100, RV, 1'b1);
    m_pc      = RV;
    m_pending = 1'b0;
    m_halted  = 1'b0;
  endtask

  task automatic halted_cycles(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(1'b1, rbit(), rbit(), rbit(), rbit(), $urandom, 3'b000, HALT, 1'b0);
  endtask

  // One instruction: w fetch wait states, optional EXEC2 with s stall cycles,
  // optional branches in EXEC1/EXEC2. limit>0 drives only that many cycles
  // (the caller then resets) and the model does not commit.
  task automatic run_instr(input int w, input bit ex2, input int s,
                           input bit b1, input logic [31:0] t1,
                           input bit b2, input logic [31:0] t2, input int limit);
    cyc_t        cl[$];
    cyc_t        c;
    logic [31:0] p;
    bit          seen;
    logic [31:0] tgt;
    int          n;
    p    = m_pc;
    seen = 1'b0;
    tgt  = 32'd0;
    for (int i = 0; i <= w; i++) begin
      c = '{wr: (i < w), ds: rbit(), ne: rbit(), bv: rbit(), bt: $urandom, strb: 3'b100};
      cl.push_back(c);
    end
    c = '{wr: rbit(), ds: rbit(), ne: ex2, bv: b1, bt: (b1 ? t1 : $urandom), strb: 3'b010};
    cl.push_back(c);
    if (b1) begin seen = 1'b1; tgt = t1; end
    if (ex2) begin
      for (int j = 0; j <= s; j++) begin
        c = '{wr: rbit(), ds: (j < s), ne: rbit(), bv: b2, bt: (b2 ? t2 : $urandom), strb: 3'b001};
        cl.push_back(c);
      end
      if (b2) begin seen = 1'b1; tgt = t2; end
    end
    n = (limit > 0 && limit < cl.size()) ? limit : cl.size();
    for (int k = 0; k < n; k++)
      drive_cycle(1'b1, cl[k].wr, cl[k].ds, cl[k].ne, cl[k].bv, cl[k].bt, cl[k].strb, p, 1'b1);
    if (n == cl.size()) begin
      if (m_pending) begin
        m_pc      = m_target;
        m_pending = 1'b0;
        if (m_pc == HALT) m_halted = 1'b1;
      end else begin
        m_pc = p + 32'd4;
        if (seen) begin
          m_pending = 1'b1;
          m_target  = tgt;
        end
      end
    end
  endtask

  task automatic plain(input int count);
    for (int i = 0; i < count; i++) run_instr(0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (end_req) begin
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL leftover_expect: got %0d unchecked entries, want 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({fetch, exec1, exec2} == e.strb && instr_read == e.strb[2] &&
          active == e.act && pc == e.pc && instr_address == e.pc &&
          pc_link == e.pc + 32'd8)
        passed++;
      else
        $display("FAIL cycle_check_%0d: got strb=%b rd=%b act=%b pc=%h addr=%h link=%h; want strb=%b rd=%b act=%b pc=%h link=%h",
                 checks, {fetch, exec1, exec2}, instr_read, active, pc, instr_address,
                 pc_link, e.strb, e.strb[2], e.act, e.pc, e.pc + 32'd8);
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    do_reset(3);
    // Straight-line code, minimum latency.
    plain(3);
    // Fetch wait states.
    do_reset(1);
    run_instr(3, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    plain(1);
    // Branch with delay slot.
    do_reset(1);
    run_instr(0, 1'b0, 0, 1'b1, 32'hBFC0_0100, 1'b0, 0, 0);
    plain(2);
    // Two-exec instruction with data stalls; EXEC2 target beats EXEC1.
    do_reset(1);
    run_instr(0, 1'b1, 2, 1'b0, 0, 1'b0, 0, 0);
    run_instr(1, 1'b1, 1, 1'b1, 32'h1000_0000, 1'b1, 32'h2000_0040, 0);
    run_instr(0, 1'b1, 0, 1'b1, 32'h3000_0000, 1'b1, 32'h3000_0008, 0);
    plain(2);
    // Jump to HALT_ADDR then its delay slot; halted with noisy inputs.
    do_reset(1);
    run_instr(0, 1'b0, 0, 1'b1, HALT, 1'b0, 0, 0);
    plain(1);
    halted_cycles(6);
    // Reset mid-EXEC2 with a branch pending, then mid-FETCH stall.
    do_reset(1);
    run_instr(0, 1'b1, 3, 1'b1, 32'hBFC0_0100, 1'b0, 0, 3);
    do_reset(1);
    plain(3);
    run_instr(4, 1'b0, 0, 1'b1, 32'h0000_1000, 1'b0, 0, 2);
    do_reset(2);
    plain(2);
    // Wrap-around of pc near the top of the address space.
    run_instr(0, 1'b0, 0, 1'b1, 32'hFFFF_FFF8, 1'b0, 0, 0);
    plain(4);
    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      if (m_halted) begin
        halted_cycles($urandom_range(1, 3));
        do_reset($urandom_range(1, 2));
      end else begin
        int  w, s, lim;
        bit  x2, b1, b2;
        w   = (($urandom % 3) == 0) ? $urandom_range(1, 3) : 0;
        x2  = rbit();
        s   = (($urandom % 2) == 0) ? $urandom_range(0, 3) : 0;
        b1  = (($urandom % 4) == 0);
        b2  = (($urandom % 4) == 0);
        lim = (($urandom % 20) == 0) ? $urandom_range(1, 2 + w) : 0;
        run_instr(w, x2, s, b1, rtarget(), b2, rtarget(), lim);
        if (lim > 0) do_reset($urandom_range(1, 2));
      end
    end
    @(posedge clk);
    #1 end_req = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL monitor_timeout: got no summary, want summary within 10 cycles");
    $fatal(1, "monitor did not finish");
  end

endmodule
